// File: rtl/wb_sram_wbuf.sv
// Wishbone posted-write buffer in front of the 16-bit SRAM controller; writes ack on FIFO entry.
// Optional `WB_SRAM_WBUF_READ_BYPASS_EN lets non-conflicting reads overtake buffered writes.
module wb_sram_wbuf #(
  parameter int unsigned depth_log2 = 2,
  parameter int unsigned adr_width  = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_stb_i,
  input  logic                s_cyc_i,
  input  logic                s_we_i,
  input  logic [31:0]         s_adr_i,
  input  logic [3:0]          s_sel_i,
  input  logic [31:0]         s_dat_i,
  output logic [31:0]         s_dat_o,
  output logic                s_ack_o,
  output logic                m_stb_o,
  output logic                m_cyc_o,
  output logic                m_we_o,
  output logic [31:0]         m_adr_o,
  output logic [3:0]          m_sel_o,
  output logic [31:0]         m_dat_o,
  input  logic [31:0]         m_dat_i,
  input  logic                m_ack_i,
  output logic [depth_log2:0] level_o,
  output logic                busy_o
);
  localparam int unsigned DEPTH = 1 << depth_log2;
  localparam int unsigned EW    = adr_width + 36;
  localparam logic [depth_log2:0] L_FULL = {1'b1, {depth_log2{1'b0}}};

  typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ, M_GAP} m_state_t;

  m_state_t              r_state, w_next;
  logic [EW-1:0]         r_fifo [DEPTH];
  logic [depth_log2-1:0] r_wptr, r_rptr;
  logic [depth_log2:0]   r_level;
  logic                  r_s_ack, r_m_cyc, r_m_stb, r_m_we;
  logic [31:0]           r_s_dat, r_m_adr, r_m_dat;
  logic [3:0]            r_m_sel;
  logic                  w_req, w_full, w_empty, w_push, w_pop;
  logic                  w_rd_issue, w_wr_issue, w_rd_done, w_rd_ok;
  logic [EW-1:0]         w_head;

  assign w_req   = s_stb_i & s_cyc_i & ~r_s_ack;
  assign w_full  = (r_level == L_FULL);
  assign w_empty = (r_level == '0);
  assign w_push  = w_req & s_we_i & ~w_full;
  assign w_head  = r_fifo[r_rptr];

`ifdef WB_SRAM_WBUF_READ_BYPASS_EN
  logic [DEPTH-1:0] r_valid, w_match;

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      w_match[i] = r_valid[i] & (r_fifo[i][EW-1:36] == s_adr_i[adr_width+1:2]);
  end

  // Per-slot valid bits avoid modular pointer arithmetic in the comparators.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (w_pop)  r_valid[r_rptr] <= 1'b0;
      if (w_push) r_valid[r_wptr] <= 1'b1;
    end
  end

  assign w_rd_ok = w_empty | ~(|w_match);
`else
  assign w_rd_ok = w_empty;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= M_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rd_issue = 1'b0;
    w_wr_issue = 1'b0;
    w_pop      = 1'b0;
    w_rd_done  = 1'b0;
    unique case (r_state)
      M_IDLE: begin
        if (w_req & ~s_we_i & w_rd_ok) begin
          w_rd_issue = 1'b1;
          w_next     = M_READ;
        end else if (~w_empty) begin
          w_wr_issue = 1'b1;
          w_next     = M_WRITE;
        end
      end
      M_WRITE: begin
        if (m_ack_i) begin
          w_pop  = 1'b1;
          w_next = M_GAP;
        end
      end
      M_READ: begin
        if (m_ack_i) begin
          w_rd_done = 1'b1;
          w_next    = M_GAP;
        end
      end
      M_GAP:   w_next = M_IDLE;
      default: w_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {s_adr_i[adr_width+1:2], s_sel_i, s_dat_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + depth_log2'(1);
      if (w_pop)  r_rptr <= r_rptr + depth_log2'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (depth_log2+1)'(1);
        2'b01:   r_level <= r_level - (depth_log2+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_cyc <= 1'b0;
      r_m_stb <= 1'b0;
      r_m_we  <= 1'b0;
      r_m_adr <= '0;
      r_m_sel <= '0;
      r_m_dat <= '0;
    end else if (w_rd_issue) begin
      r_m_cyc <= 1'b1;
      r_m_stb <= 1'b1;
      r_m_we  <= 1'b0;
      r_m_adr <= s_adr_i;
      r_m_sel <= s_sel_i;
    end else if (w_wr_issue) begin
      r_m_cyc <= 1'b1;
      r_m_stb <= 1'b1;
      r_m_we  <= 1'b1;
      r_m_adr <= 32'({w_head[EW-1:36], 2'b00});
      r_m_sel <= w_head[35:32];
      r_m_dat <= w_head[31:0];
    end else if (w_pop | w_rd_done) begin
      r_m_cyc <= 1'b0;
      r_m_stb <= 1'b0;
    end
  end

  // Read ack only goes out if the slave is still asking for that read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_ack <= 1'b0;
      r_s_dat <= '0;
    end else begin
      r_s_ack <= w_push | (w_rd_done & s_stb_i & s_cyc_i & ~s_we_i);
      if (w_rd_done) r_s_dat <= m_dat_i;
    end
  end

  assign s_ack_o = r_s_ack;
  assign s_dat_o = r_s_dat;
  assign m_cyc_o = r_m_cyc;
  assign m_stb_o = r_m_stb;
  assign m_we_o  = r_m_we;
  assign m_adr_o = r_m_adr;
  assign m_sel_o = r_m_sel;
  assign m_dat_o = r_m_dat;
  assign level_o = r_level;
  assign busy_o  = (r_level != '0) | r_m_cyc;
endmodule

// File: tb/tb_wb_sram_wbuf.sv
// Scoreboard bench for wb_sram_wbuf: slave-side expectations queued, checked at the SRAM model and slave acks.
module tb_wb_sram_wbuf;
  localparam int DL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_stb_i, s_cyc_i, s_we_i;
  logic [31:0] s_adr_i, s_dat_i, s_dat_o;
  logic [3:0]  s_sel_i;
  logic        s_ack_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_ack_i;
  logic [DL:0] level_o;
  logic        busy_o;

  wb_sram_wbuf #(.depth_log2(DL), .adr_width(18)) dut (
    .clk(clk), .reset(reset),
    .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i),
    .s_sel_i(s_sel_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .level_o(level_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [67:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        hold_ack = 1'b0;
  int          n_mack = 0;
  int          rd_pend = -1;

  // SRAM model: acks after 2 wait cycles, checks writes against the scoreboard.
  initial begin : sram_model
    int lat;
    logic [67:0] got, exp;
    lat = 0;
    m_ack_i = 1'b0;
    m_dat_i = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (m_ack_i) begin
        m_ack_i = 1'b0;
        n_vec++;
        if (m_stb_o !== 1'b0) begin
          n_err++;
          $display("FAIL gap_after_ack: m_stb_o=%b required 0", m_stb_o);
        end
      end else if (m_cyc_o === 1'b1 && m_stb_o === 1'b1 && !hold_ack) begin
        if (lat < 2) lat++;
        else begin
          lat = 0;
          if (m_we_o) begin
            got = {m_adr_o, m_sel_o, m_dat_o};
            n_vec++;
            if (exp_wr.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_write: got adr=%h sel=%h dat=%h, none queued", m_adr_o, m_sel_o, m_dat_o);
            end else begin
              exp = exp_wr.pop_front();
              if (got !== exp) begin
                n_err++;
                $display("FAIL drain_write: got adr/sel/dat=%h required %h", got, exp);
              end
            end
            for (int b = 0; b < 4; b++)
              if (m_sel_o[b]) mem[m_adr_o[9:2]][8*b +: 8] = m_dat_o[8*b +: 8];
          end else begin
            m_dat_i = mem[m_adr_o[9:2]];
            rd_pend = exp_wr.size();
          end
          m_ack_i = 1'b1;
          n_mack++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic slv_start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
    s_adr_i = adr; s_sel_i = sel; s_dat_i = dat;
    if (we) begin
      exp_wr.push_back({12'h000, adr[19:2], 2'b00, sel, dat});
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
    end else begin
      exp_rd.push_back(ref_mem[adr[9:2]]);
    end
  endtask

  // Waits up to max_cyc edges for s_ack_o; releases the bus only when acked.
  task automatic slv_wait(input int max_cyc, output bit acked, output int ncyc,
                          output logic [31:0] rdata);
    acked = 1'b0; ncyc = 0; rdata = '0;
    while (!acked && ncyc < max_cyc) begin
      @(posedge clk); #1;
      ncyc++;
      if (s_ack_o === 1'b1) begin
        acked = 1'b1;
        rdata = s_dat_o;
      end
    end
    if (acked) begin
      s_stb_i = 1'b0; s_cyc_i = 1'b0;
    end
  endtask

  task automatic slv_drop();
    s_stb_i = 1'b0; s_cyc_i = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk); #1;
      if (busy_o === 1'b0 && exp_wr.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (s_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_s_ack: got %b required 0", s_ack_o); end
    n_vec++; if (s_dat_o !== 32'h0) begin n_err++; $display("FAIL rst_s_dat: got %h required 0", s_dat_o); end
    n_vec++; if ({m_cyc_o, m_stb_o, m_we_o} !== 3'b000) begin n_err++; $display("FAIL rst_m_ctl: got %b required 000", {m_cyc_o, m_stb_o, m_we_o}); end
    n_vec++; if ({m_adr_o, m_sel_o, m_dat_o} !== 68'h0) begin n_err++; $display("FAIL rst_m_bus: got %h required 0", {m_adr_o, m_sel_o, m_dat_o}); end
    n_vec++; if ({level_o, busy_o} !== 4'h0) begin n_err++; $display("FAIL rst_level_busy: got %h required 0", {level_o, busy_o}); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    bit ok; int n; logic [31:0] rd;
    slv_start(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    slv_wait(10, ok, n, rd);
    n_vec++; if (!ok || n != 1) begin n_err++; $display("FAIL write_latency: acked=%0d after %0d cycles required 1 after 1", ok, n); end
    n_vec++; if (level_o !== 3'd1) begin n_err++; $display("FAIL write_level: got %0d required 1", level_o); end
    if (!ok) slv_drop();
    wait_drain(100, ok);
    n_vec++; if (!ok || level_o !== 3'd0) begin n_err++; $display("FAIL single_drain: drained=%0d level=%0d required 1/0", ok, level_o); end
  endtask

  task automatic test_back_to_back();
    bit ok; int n, m0; logic [31:0] rd;
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_start(1'b1, 32'h80 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i));
      slv_wait(4, ok, n, rd);
      n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_ack%0d: acked=0 required 1", i); slv_drop(); end
    end
    slv_start(1'b1, 32'h90, 4'hF, 32'hA000_0004);
    slv_wait(8, ok, n, rd);
    n_vec++; if (ok) begin n_err++; $display("FAIL full_stall: acked=1 required 0"); end
    n_vec++; if (level_o !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d required 4", level_o); end
    m0 = n_mack;
    hold_ack = 1'b0;
    if (!ok) begin
      slv_wait(50, ok, n, rd);
      n_vec++; if (!ok || n_mack != m0 + 1) begin n_err++; $display("FAIL fifth_ack: acked=%0d master_acks=%0d required 1/%0d", ok, n_mack - m0, 1); end
      if (!ok) slv_drop();
    end
    wait_drain(200, ok);
    n_vec++; if (!ok || level_o !== 3'd0) begin n_err++; $display("FAIL b2b_drain: drained=%0d level=%0d required 1/0", ok, level_o); end
  endtask

  task automatic test_read_after_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    bit ok; int n; logic [31:0] rd, exp;
    slv_start(1'b1, adr, sel, dat);
    slv_wait(4, ok, n, rd);
    if (!ok) slv_drop();
    slv_start(1'b0, adr, 4'hF, 32'h0);
    slv_wait(100, ok, n, rd);
    exp = exp_rd.pop_front();
    n_vec++; if (!ok || rd !== exp) begin n_err++; $display("FAIL raw_data@%h: acked=%0d got %h required %h", adr, ok, rd, exp); end
    n_vec++; if (rd_pend != 0) begin n_err++; $display("FAIL raw_order@%h: %0d writes pending at read, required 0", adr, rd_pend); end
    if (!ok) slv_drop();
    wait_drain(50, ok);
  endtask

  task automatic test_read_order(input logic [31:0] radr, input int exp_pend);
    bit ok; int n; logic [31:0] rd, exp;
    hold_ack = 1'b1;
    slv_start(1'b1, 32'h100, 4'hF, 32'h0100_0000 + radr);
    slv_wait(4, ok, n, rd);
    if (!ok) slv_drop();
    slv_start(1'b1, 32'h104, 4'hF, 32'h0104_0000 + radr);
    slv_wait(4, ok, n, rd);
    if (!ok) slv_drop();
    slv_start(1'b0, radr, 4'hF, 32'h0);
    slv_wait(3, ok, n, rd);
    hold_ack = 1'b0;
    if (!ok) slv_wait(100, ok, n, rd);
    exp = exp_rd.pop_front();
    n_vec++; if (!ok || rd !== exp) begin n_err++; $display("FAIL order_data@%h: acked=%0d got %h required %h", radr, ok, rd, exp); end
    n_vec++; if (rd_pend != exp_pend) begin n_err++; $display("FAIL order_pending@%h: got %0d required %0d", radr, rd_pend, exp_pend); end
    if (!ok) slv_drop();
    wait_drain(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL order_drain@%h: drained=0 required 1", radr); end
  endtask

  task automatic test_reset_midop();
    bit ok; int n, hi, m0; logic [31:0] rd;
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_start(1'b1, 32'hC0 + 32'(4*i), 4'hF, 32'hC000_0000 + 32'(i));
      slv_wait(4, ok, n, rd);
      if (!ok) slv_drop();
    end
    n_vec++; if (m_cyc_o !== 1'b1) begin n_err++; $display("FAIL midop_inflight: m_cyc_o=%b required 1", m_cyc_o); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({m_cyc_o, m_stb_o} !== 2'b00) begin n_err++; $display("FAIL midop_cyc: got %b required 00", {m_cyc_o, m_stb_o}); end
    n_vec++; if (level_o !== 3'd0 || busy_o !== 1'b0) begin n_err++; $display("FAIL midop_level: level=%0d busy=%b required 0/0", level_o, busy_o); end
    reset = 1'b0;
    exp_wr.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    m0 = n_mack;
    hold_ack = 1'b0;
    hi = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_cyc_o !== 1'b0) hi++;
    end
    n_vec++; if (hi != 0 || n_mack != m0) begin n_err++; $display("FAIL midop_no_writes: cyc_cycles=%0d acks=%0d required 0/0", hi, n_mack - m0); end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1);
  end

  initial begin
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    s_adr_i = '0; s_sel_i = '0; s_dat_i = '0;
    reset = 1'b1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_after_write(32'h20, 4'hF, 32'h1122_3344);
    test_read_after_write(32'h40, 4'h3, 32'hAABB_CCDD);
`ifdef WB_SRAM_WBUF_READ_BYPASS_EN
    test_read_order(32'h200, 1);
`else
    test_read_order(32'h200, 0);
`endif
    test_read_order(32'h104, 0);
    test_reset_midop();
    n_vec++; if (exp_wr.size() != 0 || exp_rd.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: wr=%0d rd=%0d required 0/0", exp_wr.size(), exp_rd.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_sram_wbuf.md
Name: wb_sram_wbuf

Overview:
- Wishbone posted-write buffer placed directly upstream of the 16-bit SRAM controller. One slave port faces the CPU/bus; one master port drives the SRAM controller.
- Writes are acknowledged as soon as they enter a small FIFO and drain to SRAM in the background, which hides the multi-cycle SRAM write cost.
- Reads are forwarded to SRAM with ordering preserved against buffered writes.

Parameters:
- depth_log2, 2, FIFO depth = 2**depth_log2 entries (allowed 1..4).
- adr_width, 18, word-address bits stored per entry: adr[adr_width+1:2]. Upper address bits are passed through as zero.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- s_stb_i  in  1  slave strobe
- s_cyc_i  in  1  slave cycle
- s_we_i  in  1  slave write enable
- s_adr_i  in  32  slave byte address
- s_sel_i  in  4  slave byte selects
- s_dat_i  in  32  slave write data
- s_dat_o  out  32  slave read data
- s_ack_o  out  1  slave acknowledge
- m_stb_o  out  1  master strobe
- m_cyc_o  out  1  master cycle
- m_we_o  out  1  master write enable
- m_adr_o  out  32  master byte address
- m_sel_o  out  4  master byte selects
- m_dat_o  out  32  master write data
- m_dat_i  in  32  master read data
- m_ack_i  in  1  master acknowledge
- level_o  out  depth_log2+1  current FIFO occupancy
- busy_o  out  1  high when FIFO is non-empty or a master cycle is in progress

Behaviour:
- Clocking and reset: reset is synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values: s_ack_o=0, s_dat_o=0, m_stb_o=0, m_cyc_o=0, m_we_o=0, m_adr_o=0, m_sel_o=0, m_dat_o=0, level_o=0, busy_o=0. FIFO read/write pointers = 0. Master FSM = M_IDLE.
- Reset mid-operation: buffered writes are discarded and any master cycle is abandoned; m_cyc_o/m_stb_o drop on the next edge.
- Slave request qualifier: req = s_stb_i & s_cyc_i & ~s_ack_o.
- s_ack_o is registered and high for exactly 1 cycle per transfer.
- Slave write path:
  - When req & s_we_i & FIFO not full, push {s_adr_i[adr_width+1:2], s_sel_i, s_dat_i} and assert s_ack_o on the next cycle (write latency 1).
  - FIFO full: no ack; the request stalls until a pop frees a slot.
  - Push and pop in the same cycle are legal; level is unchanged.
- Slave read path:
  - A read is accepted only when the FIFO is empty and the master FSM is in M_IDLE (strict ordering).
  - The master FSM then issues the read. When m_ack_i arrives, s_dat_o<=m_dat_i and s_ack_o=1 on the next cycle.
  - Buffered writes are never reordered behind a read.
- Master FSM:
  - M_IDLE:
    - If a slave read is pending and the FIFO is empty: drive m_cyc/m_stb=1, m_we=0, m_adr=s_adr_i, m_sel=s_sel_i, then go to M_READ.
    - Else if the FIFO is non-empty: present the head entry with m_we=1, m_adr={zeros, entry adr, 2'b00}, then go to M_WRITE.
    - Read has priority only when the FIFO is empty.
  - M_WRITE: hold all master outputs stable until m_ack_i. On ack: pop the head, drop m_cyc/m_stb, go to M_GAP.
  - M_READ: hold until m_ack_i. On ack: capture data, drop m_cyc/m_stb, go to M_GAP.
  - M_GAP: exactly 1 idle cycle with m_stb_o=0, then M_IDLE. This guarantees the downstream controller sees stb low after its registered ack.
- Master outputs change only in M_IDLE or on the ack edge. A spurious m_ack_i in M_IDLE/M_GAP is ignored.
- Pointers wrap modulo 2**depth_log2. Full when level == depth; empty when level == 0.
- A slave that drops stb before ack: no effect on the FIFO. A pending read is abandoned only if not yet issued. An issued read completes, and its ack is suppressed if s_stb_i is low.

Optional Feature:
- Macro: WB_SRAM_WBUF_READ_BYPASS_EN.
- Defined:
  - A slave read whose word address matches no valid FIFO entry may be issued while the FIFO is non-empty, once the master FSM reaches M_IDLE. The read then takes priority over the next drain.
  - On an address match, the read waits until the FIFO has drained.
  - Adds one comparator per entry.
- Undefined: strict ordering as described above; no comparators.

Test Plan:
- Single write 0x0000_0010 data 0xDEADBEEF sel 0xF -> s_ack_o 1 cycle later; master write appears with m_adr=0x10, m_dat=0xDEADBEEF; level returns to 0 after m_ack_i.
- Five back-to-back writes with depth 4 and m_ack_i held off -> first four acked; the fifth is not acked until the first m_ack_i, then acked the next cycle; drain order matches issue order.
- Write 0x20=0x11223344, then read 0x20 immediately -> read is not issued before the write's m_ack_i; s_dat_o=0x11223344 from the modelled SRAM.
- Write with sel=0x3 at 0x40 -> m_sel_o=0x3 and data passed unchanged; every master ack is followed by m_stb_o=0 for at least 1 cycle.
- Reset asserted with 3 entries buffered and a master write in flight -> next cycle m_cyc_o=0, level_o=0; no further master writes.
- With WB_SRAM_WBUF_READ_BYPASS_EN: 2 writes pending to 0x100/0x104, read 0x200 -> read issued before the second drain. Read 0x104 instead -> waits for both writes to drain.
